// File: rtl/melody_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer_if
// Description : Control and output bundle of the melody sequencer.
//               master : button-side driver of play/stop pulses, receives
//                        the playback outputs.
//               slave  : the sequencer itself.
//   play_pulse  1  one-cycle pulse, toggles play/pause
//   stop_pulse  1  one-cycle pulse, return to idle
//   note_div   22  divider value of the sounding note, 0 = silent
//   state       1  1 while playing
//   beat_idx    4  index of the current melody ROM entry
//   song_done   1  one-cycle pulse when the last beat completes
// Revision    : 1.0 - initial release
// ============================================================================
interface melody_sequencer_if;
    logic        play_pulse;
    logic        stop_pulse;
    logic [21:0] note_div;
    logic        state;
    logic [3:0]  beat_idx;
    logic        song_done;

    modport master (
        output play_pulse,
        output stop_pulse,
        input  note_div,
        input  state,
        input  beat_idx,
        input  song_done
    );

    modport slave (
        input  play_pulse,
        input  stop_pulse,
        output note_div,
        output state,
        output beat_idx,
        output song_done
    );
endinterface
`default_nettype wire

// File: rtl/melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : melody_sequencer
// Description : Steps through a fixed 16-note melody ROM, one note per beat,
//               and presents the registered clock-divider value of the
//               current note. The last GAP_CYCLES of every beat are silent.
//               Play/pause/stop from one-cycle button pulses.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - melody_sequencer_if.slave (pulses in, note_div,
//                        state, beat_idx, song_done out; all registered)
// Config      : MELODY_LOOP_EN - defined: loop the song forever;
//               undefined: return to idle after the last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    melody_sequencer_if.slave     bus
);

    localparam int unsigned CW          = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [CW-1:0] c_CNT_LAST = CW'(BEAT_CYCLES - 1);
    // Compared at 32 bits: with GAP_CYCLES == 0 this equals BEAT_CYCLES,
    // which may not fit in the counter width.
    localparam int unsigned c_SOUND_END = BEAT_CYCLES - GAP_CYCLES;
    localparam logic [3:0]  c_LAST_BEAT = 4'd15;

`ifdef MELODY_LOOP_EN
    localparam logic c_LOOP = 1'b1;
`else
    localparam logic c_LOOP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_idx, w_idx_nxt;
    logic          w_song_end;
    logic          w_sounding;
    logic [21:0]   r_note_div;
    logic          r_playing;
    logic          r_song_done;

    function automatic logic [3:0] rom_code(input logic [3:0] idx);
        case (idx)
            4'd0:  return 4'd1;
            4'd1:  return 4'd2;
            4'd2:  return 4'd3;
            4'd3:  return 4'd4;
            4'd4:  return 4'd5;
            4'd5:  return 4'd6;
            4'd6:  return 4'd7;
            4'd7:  return 4'd9;
            4'd8:  return 4'd9;
            4'd9:  return 4'd7;
            4'd10: return 4'd6;
            4'd11: return 4'd5;
            4'd12: return 4'd4;
            4'd13: return 4'd3;
            4'd14: return 4'd2;
            default: return 4'd1;
        endcase
    endfunction

    function automatic logic [21:0] code_div(input logic [3:0] code);
        case (code)
            4'd1:  return 22'd191570;
            4'd2:  return 22'd170648;
            4'd3:  return 22'd151515;
            4'd4:  return 22'd143266;
            4'd5:  return 22'd127551;
            4'd6:  return 22'd113636;
            4'd7:  return 22'd101215;
            4'd9:  return 22'd95420;
            4'd10: return 22'd85034;
            4'd11: return 22'd75758;
            4'd12: return 22'd71633;
            4'd13: return 22'd63776;
            4'd14: return 22'd56818;
            4'd15: return 22'd50607;
            default: return 22'd0;     // codes 0 and 8 are rests
        endcase
    endfunction

    // Next-state, counter and beat index; stop overrides play.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_song_end  = 1'b0;
        if (bus.stop_pulse) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.play_pulse) begin
                        w_state_nxt = S_PLAY;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 4'd0;
                    end
                end
                S_PLAY: begin
                    if (bus.play_pulse) begin
                        w_state_nxt = S_PAUSE;        // counter/index frozen
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + 4'd1;     // 15 wraps to 0
                        if (r_idx == c_LAST_BEAT) begin
                            w_song_end = 1'b1;
                            if (!c_LOOP) begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_PAUSE: begin
                    if (bus.play_pulse) begin
                        w_state_nxt = S_PLAY;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Outputs are derived from the next values so they change together with
    // the state they describe, one edge after the input is sampled.
    assign w_sounding = (w_state_nxt == S_PLAY) && (32'(w_cnt_nxt) < c_SOUND_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 4'd0;
            r_note_div  <= 22'd0;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_note_div  <= w_sounding ? code_div(rom_code(w_idx_nxt)) : 22'd0;
            r_playing   <= (w_state_nxt == S_PLAY);
            r_song_done <= w_song_end;
        end
    end

    assign bus.note_div  = r_note_div;
    assign bus.state     = r_playing;
    assign bus.beat_idx  = r_idx;
    assign bus.song_done = r_song_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_sequencer
// Description : Self-checking bench for melody_sequencer with BEAT_CYCLES=8,
//               GAP_CYCLES=2. A song-position model (elapsed cycles within
//               the 128-cycle song) predicts every output each cycle;
//               directed sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_sequencer;

    localparam int BEAT = 8;
    localparam int GAP  = 2;
    localparam int SONG = 16 * BEAT;

    logic clk;
    logic rst_n;

    melody_sequencer_if bus();

    melody_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int c_rom[16]  = '{1, 2, 3, 4, 5, 6, 7, 9, 9, 7, 6, 5, 4, 3, 2, 1};
    int c_freq[16] = '{0, 191570, 170648, 151515, 143266, 127551, 113636, 101215,
                       0, 95420, 85034, 75758, 71633, 63776, 56818, 50607};

    // Model: mode 0=idle 1=play 2=pause; m_e = elapsed cycles into the song.
    int   m_mode;
    int   m_e;
    logic m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_e    <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (bus.stop_pulse) begin
                m_mode <= 0;
                m_e    <= 0;
            end else if (bus.play_pulse) begin
                if (m_mode == 0) begin
                    m_mode <= 1;
                    m_e    <= 0;
                end else if (m_mode == 1) begin
                    m_mode <= 2;
                end else begin
                    m_mode <= 1;
                end
            end else if (m_mode == 1) begin
                if (m_e == SONG - 1) begin
                    m_done <= 1'b1;
                    m_e    <= 0;
`ifdef MELODY_LOOP_EN
                    m_mode <= 1;
`else
                    m_mode <= 0;
`endif
                end else begin
                    m_e <= m_e + 1;
                end
            end
        end
    end

    function automatic int exp_note();
        if (m_mode == 1 && (m_e % BEAT) < BEAT - GAP)
            return c_freq[c_rom[m_e / BEAT]];
        return 0;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int note, input int st,
                           input int idx, input int done);
        chk({tag, ".note_div"},  bus.note_div,  note);
        chk({tag, ".state"},     bus.state,     st);
        chk({tag, ".beat_idx"},  bus.beat_idx,  idx);
        chk({tag, ".song_done"}, bus.song_done, done);
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("cyc.note_div",  bus.note_div,  exp_note());
        chk("cyc.state",     bus.state,     (m_mode == 1) ? 1 : 0);
        chk("cyc.beat_idx",  bus.beat_idx,  m_e / BEAT);
        chk("cyc.song_done", bus.song_done, m_done);
    end

    // Called at posedge+3: raise play for one sampling edge.
    task automatic fire_play();
        bus.play_pulse = 1'b1;
        @(posedge clk); #3;
        bus.play_pulse = 1'b0;
    endtask

    task automatic fire_stop();
        bus.stop_pulse = 1'b1;
        @(posedge clk); #3;
        bus.stop_pulse = 1'b0;
    endtask

    // Advance to posedge+3 of the cycle in which the song position is target.
    task automatic wait_pos(input int target, input int budget);
        int n;
        n = 0;
        @(posedge clk); #3;
        while (!(m_mode == 1 && m_e == target) && n < budget) begin
            @(posedge clk); #3;
            n++;
        end
        n_checks++;
        if (!(m_mode == 1 && m_e == target)) begin
            n_errors++;
            $display("FAIL wait_pos: reached position %0d, required %0d", m_e, target);
        end
    endtask

    initial begin
        int k;
        logic seen;
        rst_n          = 1'b0;
        bus.play_pulse = 1'b0;
        bus.stop_pulse = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle after reset
        repeat (20) begin
            @(negedge clk);
            chk_all("idle", 0, 0, 0, 0);
        end

        // First beat: 6 sounding cycles, 2 gap cycles, then beat 1
        @(posedge clk); #3;
        fire_play();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_all("beat0", (i < 6) ? 191570 : 0, 1, 0, 0);
        end
        @(negedge clk);
        chk_all("beat1", 170648, 1, 1, 0);

        // Pause at beat 3 counter 4, hold 50 cycles, resume
        wait_pos(3 * BEAT + 4, 100);
        fire_play();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk_all("pause", 0, 0, 3, 0);
        end
        @(posedge clk); #3;
        fire_play();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all("resume", (i < 2) ? 143266 : 0, 1, 3, 0);
        end
        @(negedge clk);
        chk_all("beat4", 127551, 1, 4, 0);

        // Stop, then play the whole song from the start
        @(posedge clk); #3;
        fire_stop();
        @(negedge clk);
        chk_all("stop", 0, 0, 0, 0);
        @(posedge clk); #3;
        fire_play();
        k    = 0;
        seen = 1'b0;
        while (k < 300 && !seen) begin
            @(negedge clk);
            k++;
            if (bus.song_done) seen = 1'b1;
        end
        chk("song_done_latency", k, 129);
`ifdef MELODY_LOOP_EN
        chk_all("song_end", 191570, 1, 0, 1);
`else
        chk_all("song_end", 0, 0, 0, 1);
`endif
        @(negedge clk);
        chk("song_done_width", bus.song_done, 0);

        // play and stop together at beat 5: stop wins
        @(posedge clk); #3;
        fire_stop();
        fire_play();
        wait_pos(5 * BEAT + 2, 100);
        bus.play_pulse = 1'b1;
        bus.stop_pulse = 1'b1;
        @(posedge clk); #3;
        bus.play_pulse = 1'b0;
        bus.stop_pulse = 1'b0;
        @(negedge clk);
        chk_all("play_stop", 0, 0, 0, 0);

        // Asynchronous reset mid-beat
        @(posedge clk); #3;
        fire_play();
        wait_pos(3, 50);
        chk_all("pre_reset", 191570, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
